ps2_scan_rx: RTL and testbench
==============================

# ps2_scan_rx

Parametrised PS/2 keyboard receiver that turns raw `ps2clk`/`ps2data` pin activity into decoded key events. It sits between the PS/2 pins and the display/control logic. It adds the following over the first-generation receiver:
- input synchronisation and glitch filtering;
- odd-parity and stop-bit checking, plus a mid-frame timeout;
- E0/F0 prefix folding into one event per key action;
- an event FIFO with valid/ready backpressure.

## Interface
Parameters:
- `FILTER_LEN`, 4: consecutive identical synchronised samples needed before the filtered `ps2clk` changes (range 1..15).
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles inside a frame before it is aborted (≥ 2).
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `ps2clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2data` in 1: raw PS/2 data pin, asynchronous.
- `ev_valid` out 1: FIFO non-empty; head event presented.
- `ev_ready` in 1: consumer accepts the head event when `ev_valid & ev_ready`.
- `ev_code` out 8: scan code of the head event.
- `ev_ext` out 1: head event was preceded by E0.
- `ev_break` out 1: head event was preceded by F0 (key release).
- `err_parity` out 1: one-cycle pulse on a parity failure.
- `err_frame` out 1: one-cycle pulse on a bad stop bit or a timeout.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of stored events.

## Operation
- **Input conditioning.**
  - Each pin passes through 2 flip-flops; both reset to 1.
  - Filtered clock `fclk` resets to 1. It takes the synchronised value after `FILTER_LEN` consecutive equal samples differing from the current `fclk`.
  - `fall` is a one-cycle strobe on an `fclk` 1→0 transition. Data is sampled from the synchronised `ps2data` in the `fall` cycle.
- **Frame FSM.** States are IDLE, SHIFT and CHECK.
  - IDLE: on `fall` with data 0 (start bit), clear the bit counter and go to SHIFT. On `fall` with data 1, stay in IDLE with no error.
  - SHIFT: on each `fall`, shift data in (LSB first) and increment the counter. After the 10th bit (8 data, parity, stop), go to CHECK.
  - SHIFT timeout counter: cleared on entry and on each `fall`. When it reaches `TIMEOUT_CYCLES`: pulse `err_frame`, discard the partial frame, clear the prefix flags, go to IDLE.
  - CHECK (exactly 1 cycle, then IDLE):
    - parity good ⇔ XOR(data[7:0], parity) == 1;
    - stop good ⇔ stop == 1;
    - if stop is bad, pulse `err_frame`; else if parity is bad, pulse `err_parity`. Either error discards the byte and clears both prefix flags;
    - otherwise, decode the byte.
- **Decode** (good bytes only):
  - E0 sets `ext_f`.
  - F0 sets `brk_f`.
  - Any other byte pushes {`ext_f`, `brk_f`, byte} and clears both flags. This happens even if the push is dropped on overflow.
- **FIFO.**
  - 10-bit entries, first-word fall-through: the head is always on `ev_*`.
  - The push occurs in the cycle after CHECK.
  - Full with no pop: the push is dropped and `overflow` pulses.
  - Full with a simultaneous pop: both occur and the level stays at `FIFO_DEPTH`.
  - Empty: `ev_ready` is ignored.
- **Reset** (any time, including mid-frame):
  - FSM to IDLE; counters, flags and FIFO cleared.
  - `ev_valid`, `ev_code`, `ev_ext`, `ev_break`, `err_parity`, `err_frame`, `overflow` and `fifo_level` all 0.

## Timing
- Pin edge to `fall`: 2 + `FILTER_LEN` cycles.
- `fall` of the stop bit = cycle N. CHECK = N+1; push = N+2. With an empty FIFO, `ev_valid` = 1 at N+2.
- Error pulses are asserted in cycle N+1. A timeout pulse is asserted in the cycle the counter reaches `TIMEOUT_CYCLES`.
- `ev_valid` may stay high indefinitely. `ev_*` must remain stable until accepted.
- Pop takes effect at the next edge; the new head is visible one cycle after the handshake.
- Events are stored and delivered in the order they are received.

## Test plan
- **Make code:** frame 0, 0x1C LSB-first, parity 0, stop 1 → one event `ev_code`=1C, `ev_ext`=0, `ev_break`=0; `fifo_level` 0→1→0 after handshake.
- **Extended break:** E0, F0, 74 → exactly one event 74, `ev_ext`=1, `ev_break`=1; then 74 alone → 74 with both flags 0.
- **Parity error:** F0, then 0x1C with parity 1, then good 0x1C → `err_parity` pulses once and the only event is 1C with `ev_break`=0. Stop bit 0 on 0x1C → `err_frame` pulses once and there is no event.
- **Timeout:** start bit + 4 data bits, then `ps2clk` held high → `err_frame` pulses after `TIMEOUT_CYCLES`; a following good 0x29 frame → event 29.
- **Backpressure:** `ev_ready`=0, send `FIFO_DEPTH`+1 make codes 0x10..0x14 (depth 4) → `fifo_level`=4, one `overflow` pulse. Draining yields 10, 11, 12, 13 in order. Pop and push in the same cycle while full keeps the level at 4.
- **Glitch/reset:**
  - a low pulse on `ps2clk` of `FILTER_LEN`−1 cycles inside a frame → no bit counted, and the frame still decodes correctly;
  - `rst` asserted after 5 bits → all outputs 0 and the FSM in IDLE; the next full frame decodes normally.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, frame
// FSM with parity/stop/timeout checks, E0/F0 prefix folding and a
// first-word fall-through event FIFO with valid/ready backpressure.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
  logic          fclk_q, fclk_d, fall_q, fall_d;
  logic [3:0]    filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_f_q, ext_f_d, brk_f_q, brk_f_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic timeout, good, push, full, pop, wr_en, is_e0, is_f0;
  logic [9:0] head;

  // Synchroniser shifts and clock glitch filter: fclk flips only after
  // FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_s_d    = {clk_s_q[0], ps2clk};
    dat_s_d    = {dat_s_q[0], ps2data};
    fclk_d     = fclk_q;
    filt_cnt_d = '0;
    if (clk_s_q[1] != fclk_q) begin
      if (filt_cnt_q == 4'(FILTER_LEN - 1)) fclk_d = clk_s_q[1];
      else                                  filt_cnt_d = filt_cnt_q + 4'd1;
    end
    fall_d = fclk_q & ~fclk_d;
  end

  // Frame FSM state register plus conditioning and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      fclk_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      ext_f_q    <= 1'b0;
      brk_f_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_s_q    <= clk_s_d;
      dat_s_q    <= dat_s_d;
      fclk_q     <= fclk_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      ext_f_q    <= ext_f_d;
      brk_f_q    <= brk_f_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: start bit detection, LSB-first shifting, idle timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (fall_q && !dat_s_q[1]) begin
          bit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = S_IDLE;
        end else if (fall_q) begin
          shift_d   = {dat_s_q[1], shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = '0;
          if (bit_cnt_q == 4'd9) state_d = S_CHECK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs of the frame FSM: error pulses and the decoded-byte push strobe.
  always_comb begin
    is_e0      = (shift_q[7:0] == 8'hE0);
    is_f0      = (shift_q[7:0] == 8'hF0);
    timeout    = (state_q == S_SHIFT) && (tmo_q == TW'(TIMEOUT_CYCLES));
    good       = (state_q == S_CHECK) && shift_q[9] && (^shift_q[8:0]);
    err_frame  = timeout || ((state_q == S_CHECK) && !shift_q[9]);
    err_parity = (state_q == S_CHECK) && shift_q[9] && !(^shift_q[8:0]);
    push       = good && !is_e0 && !is_f0;
  end

  // Prefix flags: set by E0/F0, cleared by any event or any frame error.
  always_comb begin
    ext_f_d = ext_f_q;
    brk_f_d = brk_f_q;
    if (timeout || err_frame || err_parity || push) begin
      ext_f_d = 1'b0;
      brk_f_d = 1'b0;
    end else if (good && is_e0) begin
      ext_f_d = 1'b1;
    end else if (good && is_f0) begin
      brk_f_d = 1'b1;
    end
  end

  // FIFO control; a pop frees a slot for a push in the same cycle.
  always_comb begin
    fifo_level = wr_ptr_q - rd_ptr_q;
    full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    ev_valid   = (fifo_level != '0);
    pop        = ev_valid && ev_ready;
    wr_en      = push && (!full || pop);
    wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    overflow_d = push && full && !pop;
    overflow   = overflow_q;
    head       = mem_q[rd_ptr_q[AW-1:0]];
    ev_code    = ev_valid ? head[7:0] : 8'h00;
    ev_break   = ev_valid && head[8];
    ev_ext     = ev_valid && head[9];
  end

  // Event storage; contents are only visible through ev_valid gating.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {ext_f_q, brk_f_q, shift_q[7:0]};
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: drives PS/2 frames on the pins and checks
// decoded events, error pulses, FIFO level and backpressure behaviour.
module tb_ps2_scan_rx;
  localparam int FL = 4;
  localparam int TO = 300;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_break, err_parity, err_frame, overflow;
  logic [7:0] ev_code;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (err_parity) n_perr++;
    if (err_frame)  n_ferr++;
    if (overflow)   n_ovf++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame on the pins; nbits<11 gives a truncated frame. glitch_bit
  // inserts an FL-1 cycle low pulse before that bit's real falling edge.
  // pop_at_stop raises ev_ready for the single cycle in which the stop
  // bit's event is written.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      idle(4);
      if (i == glitch_bit) begin
        ps2clk = 1'b0;
        idle(FL - 1);
        ps2clk = 1'b1;
        idle(8);
      end
      ps2clk = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (pop_at_stop && i == 10) ev_ready = (k == 7);
      end
      ps2clk = 1'b1;
      idle(4);
    end
    ps2data = 1'b1;
    idle(20);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1, 1'b0);
  endtask

  // Waits (bounded) for the head event, captures it and accepts it.
  task automatic get_event(output bit got, output logic [7:0] code, output logic e, output logic br);
    got = 1'b0; code = 8'h00; e = 1'b0; br = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ev_valid) begin
        got = 1'b1; code = ev_code; e = ev_ext; br = ev_break;
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    idle(3);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_break, err_parity, err_frame, overflow} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {ev_valid, ev_code, ev_ext, ev_break, err_parity, err_frame, overflow});
    end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_make;
    bit got; logic [7:0] c; logic e, br;
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL make_level0: got %0d want 0", fifo_level); end
    good_frame(8'h1C);
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL make_level1: got %0d want 1", fifo_level); end
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL make_event: got v=%0d code=%h ext=%0d brk=%0d want 1 1C 0 0", got, c, e, br);
    end
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL make_level_after: got %0d want 0", fifo_level); end
    $display("make: code=%h ext=%0d brk=%0d", c, e, br);
  endtask

  task automatic test_ext_break;
    bit got; logic [7:0] c; logic e, br;
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h74);
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL extbrk_level: got %0d want 1", fifo_level); end
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h74, 1'b1, 1'b1}) begin
      errors++; $display("FAIL extbrk_event: got v=%0d code=%h ext=%0d brk=%0d want 1 74 1 1", got, c, e, br);
    end
    $display("ext_break: code=%h ext=%0d brk=%0d", c, e, br);
    good_frame(8'h74);
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h74, 1'b0, 1'b0}) begin
      errors++; $display("FAIL extbrk_plain: got v=%0d code=%h ext=%0d brk=%0d want 1 74 0 0", got, c, e, br);
    end
    $display("plain: code=%h ext=%0d brk=%0d", c, e, br);
  endtask

  task automatic test_parity;
    bit got; logic [7:0] c; logic e, br; int p0, f0;
    p0 = n_perr; f0 = n_ferr;
    good_frame(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0);
    good_frame(8'h1C);
    checks++;
    if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_pulses: got %0d want 1", n_perr - p0); end
    checks++;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL parity_no_frame_err: got %0d want 0", n_ferr - f0); end
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL parity_level: got %0d want 1", fifo_level); end
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL parity_event: got v=%0d code=%h ext=%0d brk=%0d want 1 1C 0 0", got, c, e, br);
    end
    $display("parity: perr=%0d code=%h brk=%0d", n_perr - p0, c, br);
    f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
    checks++;
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_pulses: got %0d want 1", n_ferr - f0); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL stop_level: got %0d want 0", fifo_level); end
    $display("bad stop: ferr=%0d level=%0d", n_ferr - f0, fifo_level);
  endtask

  task automatic test_timeout;
    bit got; logic [7:0] c; logic e, br; int f0;
    f0 = n_ferr;
    send_frame(8'h5A, 1'b0, 1'b0, 5, -1, 1'b0);
    checks++;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL timeout_early: got %0d want 0", n_ferr - f0); end
    idle(TO + 50);
    checks++;
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", n_ferr - f0); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL timeout_level: got %0d want 0", fifo_level); end
    good_frame(8'h29);
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h29, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_next: got v=%0d code=%h ext=%0d brk=%0d want 1 29 0 0", got, c, e, br);
    end
    $display("timeout: ferr=%0d next=%h", n_ferr - f0, c);
  endtask

  task automatic test_backpressure;
    bit got; logic [7:0] c; logic e, br; int o0;
    logic [7:0] exp_codes [4];
    exp_codes[0] = 8'h11; exp_codes[1] = 8'h12; exp_codes[2] = 8'h13; exp_codes[3] = 8'h15;
    o0 = n_ovf;
    for (int i = 0; i < 5; i++) good_frame(8'h10 + 8'(i));
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_full: got %0d want 4", fifo_level); end
    checks++;
    if (n_ovf - o0 !== 1) begin errors++; $display("FAIL bp_overflow: got %0d want 1", n_ovf - o0); end
    checks++;
    if (ev_code !== 8'h10) begin errors++; $display("FAIL bp_head: got %h want 10", ev_code); end
    // Pop of 10 coincides with the write of 15 while full.
    send_frame(8'h15, 1'b0, 1'b0, 11, -1, 1'b1);
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_poppush: got %0d want 4", fifo_level); end
    checks++;
    if (n_ovf - o0 !== 1) begin errors++; $display("FAIL bp_overflow_poppush: got %0d want 1", n_ovf - o0); end
    for (int i = 0; i < 4; i++) begin
      get_event(got, c, e, br);
      checks++;
      if ({got, c, e, br} !== {1'b1, exp_codes[i], 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_drain%0d: got v=%0d code=%h want %h", i, got, c, exp_codes[i]);
      end
      $display("drain %0d: code=%h", i, c);
    end
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL bp_level_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_glitch_reset;
    bit got; logic [7:0] c; logic e, br; int f0;
    send_frame(8'h3A, 1'b0, 1'b0, 11, 3, 1'b0);
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h3A, 1'b0, 1'b0}) begin
      errors++; $display("FAIL glitch_event: got v=%0d code=%h ext=%0d brk=%0d want 1 3A 0 0", got, c, e, br);
    end
    $display("glitch: code=%h", c);
    good_frame(8'h1C);
    good_frame(8'hF0);
    send_frame(8'h66, 1'b0, 1'b0, 5, -1, 1'b0);
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL rst_pre_level: got %0d want 1", fifo_level); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ev_valid, ev_code, ev_ext, ev_break, err_parity, err_frame, overflow, fifo_level} !== 17'd0) begin
      errors++;
      $display("FAIL rst_outputs: got %b want all zero",
               {ev_valid, ev_code, ev_ext, ev_break, err_parity, err_frame, overflow, fifo_level});
    end
    rst = 1'b0;
    idle(5);
    f0 = n_ferr;
    good_frame(8'h5A);
    get_event(got, c, e, br);
    checks++;
    if ({got, c, e, br} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_next: got v=%0d code=%h ext=%0d brk=%0d want 1 5A 0 0", got, c, e, br);
    end
    idle(TO + 20);
    checks++;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rst_no_timeout: got %0d want 0", n_ferr - f0); end
    $display("after reset: code=%h brk=%0d", c, br);
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity();
    test_timeout();
    test_backpressure();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
